// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers,
// with bounded bursts of up to MAX_BURST words per ownership.
module fifo_wr_arbiter #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_BURST  = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            i_req,
   input  logic [N_REQ*DATA_WIDTH-1:0] i_data,
   output logic [N_REQ-1:0]            o_gnt,
   output logic                        o_wr_en,
   output logic [DATA_WIDTH-1:0]       o_wr_data,
   input  logic                        i_full,
   output logic [$clog2(N_REQ)-1:0]    o_owner,
   output logic                        o_locked
);

   localparam int unsigned OW = $clog2(N_REQ);
   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   logic [OW-1:0] owner_q, owner_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          locked_q, locked_d;
   logic [OW-1:0] sel, idx;
   logic          found;
   logic          wr_en;

   // Locked owner keeps the port; otherwise search circularly from owner+1,
   // leaving the previous owner at lowest priority.
   always_comb begin
      sel   = owner_q;
      idx   = owner_q;
      found = 1'b0;
      if (locked_q && i_req[owner_q]) begin
         found = 1'b1;
      end else begin
         for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = OW'((32'(owner_q) + i) % N_REQ);
            if (!found && i_req[idx]) begin
               sel   = idx;
               found = 1'b1;
            end
         end
      end
   end

   assign wr_en = rst_n && found && !i_full;

   always_comb begin
      o_gnt     = '0;
      o_wr_data = '0;
      o_wr_en   = wr_en;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (wr_en && sel == OW'(k)) begin
            o_gnt[k]  = 1'b1;
            o_wr_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      locked_d = locked_q;
      if (wr_en) begin
         if (locked_q && sel == owner_q) begin
            cnt_d = cnt_q + CW'(1);
         end else begin
            owner_d = sel;
            cnt_d   = CW'(1);
         end
         locked_d = (32'(cnt_d) < MAX_BURST);
      end else if (!i_full && !found) begin
         locked_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q  <= OW'(N_REQ - 1);
         cnt_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
      end
   end

   assign o_owner  = owner_q;
   assign o_locked = locked_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a burst-budget model checked every cycle, a
// depth-4 FIFO stub on the write port, and directed scenarios with literals.
module tb_fifo_wr_arbiter;

   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int MAXB = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  i_req = '0;
   logic [N*DW-1:0] i_data = '0;
   logic [N-1:0]  o_gnt;
   logic          o_wr_en;
   logic [DW-1:0] o_wr_data;
   logic          i_full;
   logic [1:0]    o_owner;
   logic          o_locked;

   logic          stall = 1'b0;
   logic          rd_en = 1'b0;
   logic          full_q = 1'b0;
   logic [DW-1:0] fq[$];

   int pass_cnt = 0;
   int tot_cnt  = 0;

   // Model state: current owner and words left in its burst budget.
   int m_owner = N - 1;
   int m_left  = 0;

   logic [63:0] glog = '0;
   logic [63:0] olog = '0;
   logic [63:0] drained = '0;

   fifo_wr_arbiter #(
      .N_REQ(N),
      .DATA_WIDTH(DW),
      .MAX_BURST(MAXB)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .i_req(i_req),
      .i_data(i_data),
      .o_gnt(o_gnt),
      .o_wr_en(o_wr_en),
      .o_wr_data(o_wr_data),
      .i_full(i_full),
      .o_owner(o_owner),
      .o_locked(o_locked)
   );

   always #5 clk = ~clk;

   assign i_full = full_q | stall;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   function automatic int exp_sel();
      if (!rst_n || i_full || i_req == '0) return -1;
      if (m_left > 0 && i_req[m_owner]) return m_owner;
      for (int i = 1; i <= N; i++) begin
         if (i_req[(m_owner + i) % N]) return (m_owner + i) % N;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int g;
      if (!rst_n) begin
         m_owner = N - 1;
         m_left  = 0;
      end else begin
         g = exp_sel();
         if (g >= 0) begin
            if (g == m_owner && m_left > 0) m_left--;
            else begin
               m_owner = g;
               m_left  = MAXB - 1;
            end
         end else if (!i_full && i_req == '0) begin
            m_left = 0;
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin : fifo_stub
      if (!rst_n) begin
         fq.delete();
         full_q <= 1'b0;
      end else begin
         if (rd_en && fq.size() > 0) drained = (drained << 8) | 64'(fq.pop_front());
         if (o_wr_en) fq.push_back(o_wr_data);
         full_q <= (fq.size() >= 4);
      end
   end

   always @(negedge clk) begin : compare
      int g;
      logic [3:0] eg;
      logic [7:0] ed;
      g  = exp_sel();
      eg = '0;
      ed = '0;
      if (g >= 0) begin
         eg[g] = 1'b1;
         ed    = i_data[g*DW +: DW];
      end
      chk("gnt", 64'(o_gnt), 64'(eg));
      chk("wr_en", 64'(o_wr_en), 64'(g >= 0));
      chk("wr_data", 64'(o_wr_data), 64'(ed));
      chk("owner", 64'(o_owner), 64'(m_owner));
      chk("locked", 64'(o_locked), 64'(m_left > 0));
      if (o_wr_en) glog = (glog << 4) | 64'(o_gnt);
   end

   task automatic setin(input logic [3:0] req, input logic st, input logic rd);
      i_req = req;
      stall = st;
      rd_en = rd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      olog = (olog << 4) | 64'(o_owner);
   endtask

   task automatic drive(input logic [3:0] req, input logic st, input logic rd);
      setin(req, st, rd);
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      setin(4'b0000, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      glog = '0;
      olog = '0;
      drained = '0;
   endtask

   initial begin
      // Single requester fills the FIFO, then is blocked, then drain.
      do_reset();
      chk("reset_owner", 64'(o_owner), 64'd3);
      chk("reset_locked", 64'(o_locked), 64'd0);
      for (int w = 0; w < 4; w++) begin
         i_data[7:0] = 8'(8'h05 + w);
         drive(4'b0001, 1'b0, 1'b0);
      end
      chk("t1_grants", glog, 64'h1111);
      i_data[7:0] = 8'h09;
      setin(4'b0001, 1'b0, 1'b0);
      #1;
      chk("t1_full_gnt", 64'(o_gnt), 64'h0);
      chk("t1_full_wr_en", 64'(o_wr_en), 64'h0);
      tick();
      for (int w = 0; w < 4; w++) drive(4'b0000, 1'b0, 1'b1);
      chk("t1_drain", drained, 64'h05060708);

      // All requesting, FIFO drained continuously.
      do_reset();
      i_data = {8'h44, 8'h33, 8'h22, 8'h11};
      for (int c = 0; c < 9; c++) drive(4'b1111, 1'b0, 1'b1);
      chk("t2_grants", glog, 64'h112244881);
      chk("t2_owners", olog, 64'h001122330);

      // Early release rotates with no bubble.
      do_reset();
      drive(4'b0101, 1'b0, 1'b1);
      drive(4'b0100, 1'b0, 1'b1);
      chk("t3_grants", glog, 64'h14);
      chk("t3_owner", 64'(o_owner), 64'd2);
      chk("t3_locked", 64'(o_locked), 64'd1);

      // Full stall mid-burst keeps the lock.
      do_reset();
      drive(4'b0011, 1'b0, 1'b1);
      for (int s = 0; s < 3; s++) begin
         setin(4'b0011, 1'b1, 1'b1);
         #1;
         chk("t4_stall_gnt", 64'(o_gnt), 64'h0);
         tick();
         chk("t4_stall_locked", 64'(o_locked), 64'd1);
      end
      drive(4'b0011, 1'b0, 1'b1);
      drive(4'b0011, 1'b0, 1'b1);
      chk("t4_grants", glog, 64'h112);

      // Wrap from owner 3 with an expired burst.
      do_reset();
      drive(4'b1000, 1'b0, 1'b1);
      drive(4'b1000, 1'b0, 1'b1);
      chk("t5_owner", 64'(o_owner), 64'd3);
      chk("t5_expired", 64'(o_locked), 64'd0);
      for (int c = 0; c < 3; c++) drive(4'b1010, 1'b0, 1'b1);
      chk("t5_grants", glog, 64'h88228);

      // Asynchronous reset mid-burst.
      do_reset();
      drive(4'b0100, 1'b0, 1'b1);
      chk("t6_locked_before", 64'(o_locked), 64'd1);
      setin(4'b0100, 1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_gnt", 64'(o_gnt), 64'h0);
      chk("t6_rst_wr_en", 64'(o_wr_en), 64'h0);
      chk("t6_rst_wr_data", 64'(o_wr_data), 64'h0);
      chk("t6_rst_owner", 64'(o_owner), 64'd3);
      chk("t6_rst_locked", 64'(o_locked), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      setin(4'b0110, 1'b0, 1'b1);
      #1;
      chk("t6_first_gnt", 64'(o_gnt), 64'h2);
      tick();
      chk("t6_owner_after", 64'(o_owner), 64'd1);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter placed in front of the `fifo` block. Shares the single FIFO write port (`i_wr_en`/`i_wr_data`, back-pressured by `o_full`) between `N_REQ` producers. Supports bounded bursts, so a producer keeps the port for up to `MAX_BURST` consecutive words before it must rotate. Grants are combinational from registered arbitration state, so a granted word is written in the same cycle it is offered.

## Interface

Parameters:

- `N_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 8: word width; matches the FIFO data width.
- `MAX_BURST`, 2: maximum consecutive words per ownership, ≥1.

Ports:

- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `i_req`, input, `N_REQ`: bit k is high when requester k offers a word.
- `i_data`, input, `N_REQ*DATA_WIDTH`: word of requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- `o_gnt`, output, `N_REQ`: one-hot or zero. Requester k transfers in a cycle when `i_req[k] & o_gnt[k]`.
- `o_wr_en`, output, 1: connects to FIFO `i_wr_en`.
- `o_wr_data`, output, `DATA_WIDTH`: connects to FIFO `i_wr_data`. Carries the selected requester's word; 0 when no grant.
- `i_full`, input, 1: connects to FIFO `o_full`.
- `o_owner`, output, `$clog2(N_REQ)`: index of the current or last owner (registered).
- `o_locked`, output, 1: the owner holds the burst lock (registered state).

## Operation

- Registered state:
  - `owner`: reset value `N_REQ-1`, so the first search starts at 0.
  - `cnt`: reset value 0, width `$clog2(MAX_BURST+1)`.
  - `locked`: reset value 0.
- Selection, evaluated every cycle:
  - If `locked & i_req[owner]`, then `sel = owner`.
  - Otherwise `sel` is the first k with `i_req[k]=1`, searching circularly from `owner+1` (mod `N_REQ`) through `owner`. The previous owner therefore has the lowest priority.
- Grant and write:
  - `o_gnt = onehot(sel)` only when some `i_req` bit is set and `i_full=0`; otherwise `o_gnt = 0`.
  - `o_wr_en = |o_gnt`.
  - `o_wr_data = i_data[sel]` when `o_wr_en=1`, else 0.
- Update on a transfer (`o_wr_en=1`):
  - If `sel==owner` and `locked`, then `cnt <= cnt+1`. Otherwise `owner <= sel` and `cnt <= 1`.
  - `locked <=` (new `cnt`) < `MAX_BURST`.
  - With `MAX_BURST=1`, `locked` never sets, giving pure round-robin.
- No transfer, `i_full=1`: all state holds. The lock persists through full stalls, and `o_gnt` is 0 regardless of requests.
- No transfer, `i_full=0`, no requests: `locked <= 0` (lock dropped). `owner` and `cnt` hold.
- Owner deasserts `i_req` while locked: selection rotates in that same cycle (no idle bubble). The next winner's transfer loads `owner`/`cnt` as above.
- Burst expiry: after the `MAX_BURST`-th word, the next cycle searches from `owner+1`. If only the old owner requests, it is re-granted with `cnt=1`.
- Wrap-around: the search index is computed modulo `N_REQ`. With `owner = N_REQ-1`, the search begins at 0.

## Timing

- Grant latency: zero cycles. `o_gnt`, `o_wr_en` and `o_wr_data` are combinational from `i_req`, `i_data`, `i_full` and registered state.
- The word enters the FIFO at the same rising edge where `owner`/`cnt`/`locked` update.
- Requesters must hold `i_req` and `i_data` stable until they see `i_req & o_gnt` at a rising edge.
- `i_full` is sampled combinationally. Because the FIFO drives `o_full` from registers, no combinational loop exists.
- Reset, including assertion mid-burst:
  - State clears immediately: `o_owner = N_REQ-1`, `o_locked = 0`.
  - While `rst_n=0`: `o_gnt=0`, `o_wr_en=0`, `o_wr_data=0`, independent of inputs.
  - After release, the first grant follows the normal selection rules starting from requester 0.

## Test plan

All scenarios use the default parameters with the arbiter driving a depth-4 `fifo`.

1. **Single requester:** req0 alone, data 0x05, 0x06, 0x07, 0x08, reader idle.
   - `o_gnt=0001` for 4 cycles, and the FIFO asserts full.
   - The next offer sees `o_gnt=0000`, `o_wr_en=0`.
   - Draining the FIFO returns 05, 06, 07, 08.
2. **All requesting, FIFO drained continuously:** `i_req=1111`, `i_full=0`.
   - Grant order is 0, 0, 1, 1, 2, 2, 3, 3, 0.
   - `o_owner` after each edge is 0, 0, 1, 1, 2, 2, 3, 3, 0.
3. **Early release:** req0 and req2 high; req0 drops after one word.
   - Grants: cycle 1 → 0001, cycle 2 → 0100 (no bubble).
   - `cnt=1` under owner 2, `o_locked=1`.
4. **Full stall mid-burst:** req0 and req1 high; `i_full=1` for 3 cycles after req0's first word.
   - `o_gnt=0` during the stall, with `o_locked=1` held.
   - After the stall: req0's second word, then req1.
5. **Wrap:** `owner=3` with burst expired, requests on 1 and 3.
   - Next grant goes to requester 1, then 1 again, then 3.
6. **Async reset mid-burst:** `rst_n` asserted between clock edges while req2 holds the lock.
   - Outputs go to 0 immediately; `o_owner=3`, `o_locked=0`.
   - After release, with `i_req=0110`, the first grant goes to requester 1.
